serial_word_tx: RTL and testbench

//  Parallel-to-serial transmitter: the sending end of the serial-in/shift-enable link used by the 4-bit shift register.

---
 rtl/serial_word_tx.sv | 147 ++++++++++++++
 tb/tb_serial_word_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// ---------------------------------------------------------------------------
// serial_word_tx
//
// Parallel-to-serial transmitter. A WIDTH-bit word is accepted on a
// valid/ready handshake and shifted out MSB-first, one bit per cycle in
// which the downstream side is not holding. ShiftOut/ShiftEn are meant to
// drive a downstream shift register's serial input and shift enable
// directly. After WIDTH enabled shifts, a register that shifts left with
// serial input at its LSB holds the original word.
//
// Parameters
//   WIDTH  word length in bits (>= 2)
//   GAP    idle cycles inserted after each frame before LoadReady returns
//
// Ports
//   Clk         in   1       single clock, rising edge
//   Reset       in   1       asynchronous active-high reset
//   ParallelIn  in   WIDTH   word to transmit, sampled on the accept edge
//   LoadValid   in   1       ParallelIn is valid
//   LoadReady   out  1       block can accept a word (idle)
//   Hold        in   1       downstream stall, freezes the current bit
//   ShiftOut    out  1       serial data, MSB first, 0 when not shifting
//   ShiftEn     out  1       ShiftOut is valid and consumed this cycle
//   FrameDone   out  1       pulse coincident with the last bit's ShiftEn
//   BitCount    out  clog2(WIDTH+1)  bits remaining in the current frame
// ---------------------------------------------------------------------------
module serial_word_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [WIDTH-1:0]             ParallelIn,
  input  logic                         LoadValid,
  output logic                         LoadReady,
  input  logic                         Hold,
  output logic                         ShiftOut,
  output logic                         ShiftEn,
  output logic                         FrameDone,
  output logic [$clog2(WIDTH+1)-1:0]   BitCount
);

  localparam int CW = $clog2(WIDTH + 1);
  // GAP may be 0, which would otherwise give a zero-width counter.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_next;

  logic             accept;
  logic             last_bit;

  // Output decodes are purely combinational so that an asynchronous reset
  // or a Hold takes effect in the same cycle it is applied.
  always_comb begin
    LoadReady = (state == ST_IDLE);
    ShiftEn   = (state == ST_SHIFT) & ~Hold;
    ShiftOut  = (state == ST_SHIFT) & sreg[WIDTH-1];
    last_bit  = (count == CW'(1));
    FrameDone = ShiftEn & last_bit;
    BitCount  = count;
    accept    = LoadReady & LoadValid;
  end

  // State register and datapath registers. Reset aborts any frame in
  // flight; nothing of a partial frame survives.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      count   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      sreg    <= sreg_next;
      count   <= count_next;
      gap_cnt <= gap_next;
    end
  end

  // Next-state logic. Everything holds by default, so a Hold in SHIFT and
  // LoadValid outside IDLE both fall through to "no change". The last
  // shift leaves sreg all-zero and count at 0, which keeps BitCount at 0
  // in IDLE and GAP without extra clearing.
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    count_next = count;
    gap_next   = gap_cnt;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          sreg_next  = ParallelIn;
          count_next = CW'(WIDTH);
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ShiftEn) begin
          sreg_next  = {sreg[WIDTH-2:0], 1'b0};
          count_next = count - CW'(1);
          if (last_bit) begin
            if (GAP > 0) begin
              gap_next   = GW'(GAP);
              state_next = ST_GAP;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end

      ST_GAP: begin
        // Hold is deliberately ignored here; the gap always runs at
        // full speed.
        if (gap_cnt <= GW'(1)) begin
          gap_next   = '0;
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_cnt - GW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        sreg_next  = '0;
        count_next = '0;
        gap_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_word_tx
//
// Directed self-checking bench for serial_word_tx. Two instances share the
// clock and reset: one with GAP=0 for the main frame tests and one with
// GAP=2 for the inter-frame gap test. A simple 4-bit left-shifting register
// model sits on the GAP=0 instance's serial link to show end-to-end word
// transfer.
// ---------------------------------------------------------------------------
module tb_serial_word_tx;

  logic       clk;
  logic       reset;

  logic [3:0] ld_data;
  logic       ld_valid;
  logic       hold;
  logic       load_ready;
  logic       shift_out;
  logic       shift_en;
  logic       frame_done;
  logic [2:0] bit_count;

  logic [3:0] g_data;
  logic       g_valid;
  logic       g_hold;
  logic       g_ready;
  logic       g_shift_out;
  logic       g_shift_en;
  logic       g_frame_done;
  logic [2:0] g_bit_count;

  logic [3:0] reg_content;

  int checkCount = 0;
  int failCount  = 0;

  serial_word_tx #(.WIDTH(4), .GAP(0)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .ParallelIn (ld_data),
    .LoadValid  (ld_valid),
    .LoadReady  (load_ready),
    .Hold       (hold),
    .ShiftOut   (shift_out),
    .ShiftEn    (shift_en),
    .FrameDone  (frame_done),
    .BitCount   (bit_count)
  );

  serial_word_tx #(.WIDTH(4), .GAP(2)) dut_gap (
    .Clk        (clk),
    .Reset      (reset),
    .ParallelIn (g_data),
    .LoadValid  (g_valid),
    .LoadReady  (g_ready),
    .Hold       (g_hold),
    .ShiftOut   (g_shift_out),
    .ShiftEn    (g_shift_en),
    .FrameDone  (g_frame_done),
    .BitCount   (g_bit_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream 4-bit register: shifts left, serial input at the LSB.
  always @(posedge clk or posedge reset) begin
    if (reset) reg_content <= 4'h0;
    else if (shift_en) reg_content <= {reg_content[2:0], shift_out};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word to the GAP=0 instance while it is idle and check the
  // full frame bit by bit. ParallelIn is scrambled after the accept edge
  // to show the frame in flight does not depend on it.
  task automatic applyStimulus(input string tag, input logic [3:0] w);
    ld_valid = 1'b1;
    ld_data  = w;
    #1;
    checkOutput({tag, " ready_before"}, 64'(load_ready), 64'd1);
    tick();
    ld_valid = 1'b0;
    ld_data  = ~w;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("%s bit%0d en", tag, i), 64'(shift_en), 64'd1);
      checkOutput($sformatf("%s bit%0d out", tag, i), 64'(shift_out), 64'(w[3-i]));
      checkOutput($sformatf("%s bit%0d done", tag, i), 64'(frame_done), 64'(i == 3));
      checkOutput($sformatf("%s bit%0d ready", tag, i), 64'(load_ready), 64'd0);
      checkOutput($sformatf("%s bit%0d count", tag, i), 64'(bit_count), 64'(4 - i));
      tick();
    end
    #1;
    checkOutput({tag, " ready_after"}, 64'(load_ready), 64'd1);
    checkOutput({tag, " en_after"}, 64'(shift_en), 64'd0);
    checkOutput({tag, " count_after"}, 64'(bit_count), 64'd0);
  endtask

  initial begin
    logic [63:0] stream;
    logic [63:0] exp_stream;
    int          nbits;
    int          k;
    int          last_accept;
    int          bad_spacing;

    reset    = 1'b1;
    ld_data  = 4'h0;
    ld_valid = 1'b0;
    hold     = 1'b0;
    g_data   = 4'h0;
    g_valid  = 1'b0;
    g_hold   = 1'b0;

    // Reset state
    #3;
    checkOutput("rst ready", 64'(load_ready), 64'd1);
    checkOutput("rst en", 64'(shift_en), 64'd0);
    checkOutput("rst out", 64'(shift_out), 64'd0);
    checkOutput("rst done", 64'(frame_done), 64'd0);
    checkOutput("rst count", 64'(bit_count), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst ready", 64'(load_ready), 64'd1);
    checkOutput("post_rst en", 64'(shift_en), 64'd0);

    // 1: basic frame 1011
    applyStimulus("t1", 4'b1011);

    // 2: chained into a downstream register
    tick();
    applyStimulus("t2a", 4'hA);
    checkOutput("t2 reg A", 64'(reg_content), 64'hA);
    applyStimulus("t2b", 4'h5);
    checkOutput("t2 reg 5", 64'(reg_content), 64'h5);

    // 3: Hold for two cycles after bit 2 of 1100
    ld_valid = 1'b1;
    ld_data  = 4'hC;
    tick();
    ld_valid = 1'b0;
    #1;
    checkOutput("t3 b1", 64'({shift_en, shift_out}), 64'b11);
    tick();
    #1;
    checkOutput("t3 b2", 64'({shift_en, shift_out}), 64'b11);
    tick();
    hold = 1'b1;
    #1;
    checkOutput("t3 hold1", 64'({shift_en, shift_out}), 64'b00);
    checkOutput("t3 hold1 count", 64'(bit_count), 64'd2);
    tick();
    #1;
    checkOutput("t3 hold2", 64'({shift_en, shift_out}), 64'b00);
    checkOutput("t3 hold2 ready", 64'(load_ready), 64'd0);
    tick();
    hold = 1'b0;
    #1;
    checkOutput("t3 b3", 64'({shift_en, shift_out, frame_done}), 64'b100);
    tick();
    #1;
    checkOutput("t3 b4", 64'({shift_en, shift_out, frame_done}), 64'b101);
    tick();
    #1;
    checkOutput("t3 ready", 64'(load_ready), 64'd1);

    // 4: back-to-back stream of words 0..15 with LoadValid held high
    stream      = '0;
    nbits       = 0;
    k           = 0;
    last_accept = -1;
    bad_spacing = 0;
    for (int cyc = 0; cyc < 200 && nbits < 64; cyc++) begin
      if (load_ready) begin
        if (k < 16) begin
          ld_valid = 1'b1;
          ld_data  = 4'(k);
          if (last_accept >= 0 && cyc - last_accept != 5) bad_spacing++;
          last_accept = cyc;
          k++;
        end else begin
          ld_valid = 1'b0;
        end
      end
      #1;
      if (shift_en) begin
        stream = {stream[62:0], shift_out};
        nbits++;
      end
      tick();
    end
    ld_valid   = 1'b0;
    exp_stream = '0;
    for (int w = 0; w < 16; w++) exp_stream = {exp_stream[59:0], 4'(w)};
    checkOutput("t4 nbits", 64'(nbits), 64'd64);
    checkOutput("t4 accepts", 64'(k), 64'd16);
    checkOutput("t4 spacing", 64'(bad_spacing), 64'd0);
    checkOutput("t4 stream", stream, exp_stream);
    for (int w = 0; w < 6 && !load_ready; w++) tick();
    #1;
    checkOutput("t4 idle", 64'(load_ready), 64'd1);

    // 5: reset after bit 2 of 1111, then a clean 0011
    tick();
    ld_valid = 1'b1;
    ld_data  = 4'hF;
    tick();
    ld_valid = 1'b0;
    #1;
    checkOutput("t5 b1", 64'({shift_en, shift_out}), 64'b11);
    tick();
    #1;
    checkOutput("t5 b2", 64'({shift_en, shift_out}), 64'b11);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("t5 rst en", 64'(shift_en), 64'd0);
    checkOutput("t5 rst out", 64'(shift_out), 64'd0);
    checkOutput("t5 rst count", 64'(bit_count), 64'd0);
    checkOutput("t5 rst ready", 64'(load_ready), 64'd1);
    tick();
    reset = 1'b0;
    applyStimulus("t5", 4'h3);

    // 6: GAP=2 instance, LoadValid pulsed mid-frame, Hold during the gap
    g_valid = 1'b1;
    g_data  = 4'h6;
    tick();
    g_valid = 1'b0;
    #1;
    checkOutput("t6 b1", 64'({g_shift_en, g_shift_out}), 64'b10);
    tick();
    g_valid = 1'b1;
    g_data  = 4'h9;
    #1;
    checkOutput("t6 b2", 64'({g_shift_en, g_shift_out}), 64'b11);
    checkOutput("t6 b2 ready", 64'(g_ready), 64'd0);
    tick();
    g_valid = 1'b0;
    #1;
    checkOutput("t6 b3", 64'({g_shift_en, g_shift_out}), 64'b11);
    tick();
    #1;
    checkOutput("t6 b4", 64'({g_shift_en, g_shift_out, g_frame_done}), 64'b101);
    tick();
    g_hold = 1'b1;
    #1;
    checkOutput("t6 gap1 ready", 64'(g_ready), 64'd0);
    checkOutput("t6 gap1 en", 64'(g_shift_en), 64'd0);
    checkOutput("t6 gap1 count", 64'(g_bit_count), 64'd0);
    tick();
    #1;
    checkOutput("t6 gap2 ready", 64'(g_ready), 64'd0);
    tick();
    g_hold = 1'b0;
    #1;
    checkOutput("t6 ready", 64'(g_ready), 64'd1);
    g_valid = 1'b1;
    g_data  = 4'h5;
    tick();
    g_valid = 1'b0;
    #1;
    checkOutput("t6 next b1", 64'({g_shift_en, g_shift_out}), 64'b10);
    checkOutput("t6 next count", 64'(g_bit_count), 64'd4);
    tick();
    #1;
    checkOutput("t6 next b2", 64'({g_shift_en, g_shift_out}), 64'b11);
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
